dac_settle_sequencer: RTL
=========================

# dac_settle_sequencer

Drives the DAC A/B output codes for each control-loop step, waits a programmable settling time, then triggers one ADC averaging window and returns the averaged result. It is the initiator side of the averager start/done handshake: the averager consumes ADC samples, and this block decides when the DACs change and when a measurement may begin. It sits between the loop/optimiser logic, which supplies signed target codes, and the averager and DAC pins, all in the ADC clock domain.

## Interface
- DAC_WIDTH, 14, DAC code width.
- AVE_WIDTH, 32, width of the averaged result returned by the averager.
- CNT_WIDTH, 32, width of the settle and timeout counters (matches the GPIO/CFG word).

Ports:
- ADC_CLK  in  1  the single clock, ADC sample clock.
- ADC_RSTN  in  1  reset, asynchronous assert, active-low.
- ENABLE  in  1  sequencer enable.
- CODE_A_IN  in  DAC_WIDTH  signed two's-complement target for DAC A.
- CODE_B_IN  in  DAC_WIDTH  signed two's-complement target for DAC B.
- CODE_VALID  in  1  target pair valid.
- CODE_READY  out  1  block can accept a target pair.
- SETTLE_CYCLES  in  CNT_WIDTH  wait from DAC update to AVE_START.
- TIMEOUT_CYCLES  in  CNT_WIDTH  maximum wait for AVE_DONE; 0 means no timeout.
- DACA_CODE_OUT  out  DAC_WIDTH  offset-binary DAC A code.
- DACB_CODE_OUT  out  DAC_WIDTH  offset-binary DAC B code.
- AVE_START  out  1  one-cycle pulse that starts an averaging window.
- AVE_DONE  in  1  averager result valid, one-cycle pulse.
- AVE_DATA_IN  in  AVE_WIDTH  averaged value, qualified by AVE_DONE.
- RESULT_OUT  out  AVE_WIDTH  last captured average.
- RESULT_VALID  out  1  one-cycle pulse when a step completes.
- TIMEOUT_FLAG  out  1  sticky flag: the last step timed out.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Reset values:
  - DACA_CODE_OUT and DACB_CODE_OUT = 14'h2000 (midscale, signed 0).
  - RESULT_OUT = 0.
  - CODE_READY, AVE_START, RESULT_VALID, TIMEOUT_FLAG and BUSY = 0.
  - State = IDLE.
- Code conversion: DAC out = {~code[DAC_WIDTH-1], code[DAC_WIDTH-2:0]}. Signed −8192 maps to 0x0000 and +8191 maps to 0x3FFF. No saturation is needed.
- State machine:
  - IDLE: CODE_READY = ENABLE.
    - On CODE_VALID && CODE_READY: register both DAC outputs, capture SETTLE_CYCLES and TIMEOUT_CYCLES, clear TIMEOUT_FLAG, go to SETTLE.
  - SETTLE: down-counter loaded with the captured SETTLE_CYCLES.
    - When the count reaches 0, pulse AVE_START and go to WAIT.
    - AVE_DONE in this state is a stale result: ignore it.
  - WAIT: timeout counter runs when the captured TIMEOUT_CYCLES ≠ 0.
    - On AVE_DONE: RESULT_OUT ← AVE_DATA_IN, go to DONE.
    - On expiry without AVE_DONE: set TIMEOUT_FLAG, leave RESULT_OUT unchanged, go to DONE.
    - If AVE_DONE and expiry occur in the same cycle, AVE_DONE wins and the flag is not set.
  - DONE: pulse RESULT_VALID for one cycle, return to IDLE.
- ENABLE deassertion:
  - Blocks new handshakes only.
  - An in-flight step always runs to DONE.
  - DAC outputs hold their last value.
- Config changes mid-step have no effect, because values are captured at the handshake.
- Reset mid-step: all outputs return to their reset values immediately, including DACs back to midscale.

## Timing
- Handshake accepted at edge k:
  - DAC outputs show the new code after edge k.
  - The state is SETTLE from edge k.
- AVE_START is high during the cycle after edge k+SETTLE_CYCLES+1.
  - SETTLE_CYCLES = 0 means AVE_START is asserted in the cycle right after the DAC update.
- AVE_DONE sampled at edge m: RESULT_OUT updates and the state moves to DONE after edge m. RESULT_VALID is high during the cycle after edge m+1.
- CODE_READY returns high in the cycle after RESULT_VALID (if ENABLE is high).
- Minimum step period is SETTLE_CYCLES + averager latency + 4 cycles.
- Timeout measurement: count from the AVE_START cycle. Expiry is the TIMEOUT_CYCLES-th cycle of WAIT without AVE_DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package dac_seq_pkg holds:
  - the state enum {IDLE, SETTLE, WAIT, DONE};
  - the MIDSCALE constant (1 << (DAC_WIDTH-1));
  - the function to_offset_binary.
- One sub-module, cycle_down_counter (load, enable, zero flag, CNT_WIDTH). Instantiate it twice: once for settle, once for timeout.
- The top level contains the FSM, DAC registers and result register. Target size is about 200 lines.

## Test plan
- Reset check: release ADC_RSTN; no handshake offered.
  - DAC outputs = 0x2000 and 0x2000.
  - CODE_READY = 1 one cycle after ENABLE = 1.
- Code conversion: A = 0x1FFF, B = 0x2000 (−8192).
  - DACA = 0x3FFF, DACB = 0x0000 one cycle after the handshake.
- Settle timing: SETTLE_CYCLES = 5.
  - AVE_START rises exactly 6 cycles after the DAC update, high for 1 cycle.
  - SETTLE_CYCLES = 0 gives AVE_START in the very next cycle.
- Result capture: averager model returns 0x0000_0ABC 1024 cycles after AVE_START.
  - RESULT_OUT = 0x0ABC.
  - RESULT_VALID high for 1 cycle.
  - TIMEOUT_FLAG = 0.
  - A stale AVE_DONE injected during SETTLE is ignored.
- Timeout: TIMEOUT_CYCLES = 16, no AVE_DONE.
  - TIMEOUT_FLAG = 1, RESULT_OUT unchanged, RESULT_VALID pulses.
  - Flag clears on the next handshake.
  - AVE_DONE arriving on the expiry cycle gives flag = 0 and the captured data.
- Abort: assert ADC_RSTN low during WAIT.
  - DACs = 0x2000, BUSY = 0, no RESULT_VALID.
  - ENABLE = 0 mid-step: the step completes, then CODE_READY stays 0.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// Shared types, constants and code-conversion helper for the DAC settle/measure sequencer.
package dac_seq_pkg;

    localparam int DAC_W = 14;
    localparam int AVE_W = 32;
    localparam int CNT_W = 32;

    localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    // Signed two's-complement target to offset-binary DAC code: invert the sign bit.
    function automatic logic [DAC_W-1:0] to_offset_binary(input logic [DAC_W-1:0] code);
        return {~code[DAC_W-1], code[DAC_W-2:0]};
    endfunction

endpackage

// File: rtl/dac_settle_sequencer_cnt.sv
// Loadable down-counter that stops at zero; used for both the settle wait and the done timeout.
module cycle_down_counter
    import dac_seq_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 zero_o
);

    localparam logic [CNT_WIDTH-1:0] ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Load has priority; otherwise count down while enabled and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != ZERO)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == ZERO);

endmodule

// File: rtl/dac_settle_sequencer.sv
// Per-step sequencer: update DAC A/B, wait the settle time, run one averaging window, return the result.
module dac_settle_sequencer
    import dac_seq_pkg::*;
#(
    parameter int DAC_WIDTH = DAC_W,
    parameter int AVE_WIDTH = AVE_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 ADC_CLK,
    input  logic                 ADC_RSTN,
    input  logic                 ENABLE,
    input  logic [DAC_WIDTH-1:0] CODE_A_IN,
    input  logic [DAC_WIDTH-1:0] CODE_B_IN,
    input  logic                 CODE_VALID,
    output logic                 CODE_READY,
    input  logic [CNT_WIDTH-1:0] SETTLE_CYCLES,
    input  logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES,
    output logic [DAC_WIDTH-1:0] DACA_CODE_OUT,
    output logic [DAC_WIDTH-1:0] DACB_CODE_OUT,
    output logic                 AVE_START,
    input  logic                 AVE_DONE,
    input  logic [AVE_WIDTH-1:0] AVE_DATA_IN,
    output logic [AVE_WIDTH-1:0] RESULT_OUT,
    output logic                 RESULT_VALID,
    output logic                 TIMEOUT_FLAG,
    output logic                 BUSY
);

    localparam logic [CNT_WIDTH-1:0] ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seq_state_e           state_q, state_d;
    logic [DAC_WIDTH-1:0] daca_q, daca_d;
    logic [DAC_WIDTH-1:0] dacb_q, dacb_d;
    logic [AVE_WIDTH-1:0] result_q, result_d;
    logic                 code_ready_q, code_ready_d;
    logic                 ave_start_q, ave_start_d;
    logic                 result_valid_q, result_valid_d;
    logic                 timeout_flag_q, timeout_flag_d;
    logic                 busy_q, busy_d;
    logic                 timeout_en_q, timeout_en_d;

    logic                 accept_s;
    logic                 settle_zero_s;
    logic                 timeout_zero_s;
    logic                 settle_run_s;
    logic                 timeout_run_s;
    logic                 expired_s;
    logic [CNT_WIDTH-1:0] timeout_load_s;

    assign accept_s      = (state_q == IDLE) && CODE_VALID && code_ready_q;
    assign settle_run_s  = (state_q == SETTLE);
    assign timeout_run_s = (state_q == WAIT);
    // Loaded with T-1 so the counter reads zero during the T-th WAIT cycle; unused when T is 0.
    assign timeout_load_s = TIMEOUT_CYCLES - ONE;
    assign expired_s      = (state_q == WAIT) && timeout_en_q && timeout_zero_s;

    cycle_down_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_settle_cnt (
        .clk_i      (ADC_CLK),
        .rst_ni     (ADC_RSTN),
        .load_i     (accept_s),
        .load_val_i (SETTLE_CYCLES),
        .en_i       (settle_run_s),
        .zero_o     (settle_zero_s)
    );

    cycle_down_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timeout_cnt (
        .clk_i      (ADC_CLK),
        .rst_ni     (ADC_RSTN),
        .load_i     (accept_s),
        .load_val_i (timeout_load_s),
        .en_i       (timeout_run_s),
        .zero_o     (timeout_zero_s)
    );

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        state_d        = state_q;
        daca_d         = daca_q;
        dacb_d         = dacb_q;
        result_d       = result_q;
        timeout_en_d   = timeout_en_q;
        timeout_flag_d = timeout_flag_q;
        ave_start_d    = 1'b0;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    daca_d         = to_offset_binary(CODE_A_IN);
                    dacb_d         = to_offset_binary(CODE_B_IN);
                    timeout_en_d   = (TIMEOUT_CYCLES != ZERO);
                    timeout_flag_d = 1'b0;
                    state_d        = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                // Any AVE_DONE seen here belongs to an older window and is dropped.
                if (settle_zero_s) begin
                    ave_start_d = 1'b1;
                    state_d     = WAIT;
                end else begin
                    state_d = SETTLE;
                end
            end
            WAIT: begin
                if (AVE_DONE) begin
                    result_d = AVE_DATA_IN;
                    state_d  = DONE;
                end else if (expired_s) begin
                    timeout_flag_d = 1'b1;
                    state_d        = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        code_ready_d = (state_q == IDLE) && ENABLE && !accept_s;
    end

    // State and output registers; reset returns DACs to midscale at once.
    always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
        if (!ADC_RSTN) begin
            state_q        <= IDLE;
            daca_q         <= MIDSCALE;
            dacb_q         <= MIDSCALE;
            result_q       <= {AVE_WIDTH{1'b0}};
            code_ready_q   <= 1'b0;
            ave_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_flag_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            daca_q         <= daca_d;
            dacb_q         <= dacb_d;
            result_q       <= result_d;
            code_ready_q   <= code_ready_d;
            ave_start_q    <= ave_start_d;
            result_valid_q <= result_valid_d;
            timeout_flag_q <= timeout_flag_d;
            busy_q         <= busy_d;
            timeout_en_q   <= timeout_en_d;
        end
    end

    assign CODE_READY    = code_ready_q;
    assign DACA_CODE_OUT = daca_q;
    assign DACB_CODE_OUT = dacb_q;
    assign AVE_START     = ave_start_q;
    assign RESULT_OUT    = result_q;
    assign RESULT_VALID  = result_valid_q;
    assign TIMEOUT_FLAG  = timeout_flag_q;
    assign BUSY          = busy_q;

endmodule
